// File: rtl/alu_pkg.sv
// Shared definitions for the alu_exec execute stage: opcodes, FSM states, flag bit positions.
package alu_pkg;

  localparam int unsigned OPC_W  = 4;
  localparam int unsigned FLAG_W = 4;

  localparam logic [OPC_W-1:0] OP_ADD = 4'h0;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h1;
  localparam logic [OPC_W-1:0] OP_AND = 4'h2;
  localparam logic [OPC_W-1:0] OP_OR  = 4'h3;
  localparam logic [OPC_W-1:0] OP_XOR = 4'h4;
  localparam logic [OPC_W-1:0] OP_NOT = 4'h5;
  localparam logic [OPC_W-1:0] OP_SHL = 4'h6;
  localparam logic [OPC_W-1:0] OP_SHR = 4'h7;
  localparam logic [OPC_W-1:0] OP_MUL = 4'h8;
  localparam logic [OPC_W-1:0] OP_CMP = 4'h9;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_exec_mul_seq.sv
// Sequential shift-add multiplier: one iteration per step, last flags the cycle after the final one.
module alu_mul_seq #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [DATA_W-1:0]     mcand,
  input  logic [DATA_W-1:0]     mplier,
  output logic [2*DATA_W-1:0]   acc,
  output logic                  last
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] mc;
  logic [DATA_W:0]   sum;

  // Partial-product add into the upper half; multiplier bits sit in the lower half
  always_comb begin
    sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mc} : '0);
  end

  // Load operands, then shift the accumulator right once per step
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      acc  <= '0;
      mc   <= '0;
      last <= 1'b0;
    end else if (load) begin
      cnt  <= '0;
      acc  <= {DATA_W'(0), mplier};
      mc   <= mcand;
      last <= 1'b0;
    end else if (step) begin
      cnt  <= cnt + 1'b1;
      acc  <= {sum, acc[DATA_W-1:1]};
      last <= (cnt == CNT_W'(DATA_W - 1));
    end else begin
      last <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Execute stage: single-cycle ALU ops plus optional shift-add MUL, producing a write-back bundle.
// Build option: define ALU_MUL_EN to implement opcode 8 (MUL); otherwise it decodes as illegal.
module alu_exec
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [OPC_W-1:0]   opcode,
  input  logic [DATA_W-1:0]  op_a,
  input  logic [DATA_W-1:0]  op_b,
  input  logic [REG_AW-1:0]  dst_num,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [DATA_W-1:0]  result,
  output logic [DATA_W-1:0]  mul_high,
  output logic [REG_AW-1:0]  wr_num,
  output logic               write_en,
  output logic [FLAG_W-1:0]  flags
);

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  localparam int unsigned MSB = DATA_W - 1;

  state_t state, state_d;

  logic [OPC_W-1:0]  opc_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [REG_AW-1:0] dst_q;
  logic              latch;

  logic              busy_d, done_d, err_d, we_d;
  logic [DATA_W-1:0] result_d, mul_high_d;
  logic [REG_AW-1:0] wr_num_d;
  logic [FLAG_W-1:0] flags_d;

  logic                mul_load, mul_step, mul_last;
  logic [2*DATA_W-1:0] mul_acc;

  logic [DATA_W:0]   add9, sub9;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_v, alu_legal, alu_writes;
  logic [FLAG_W-1:0] alu_flags;

`ifdef ALU_MUL_EN
  alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .load   (mul_load),
    .step   (mul_step),
    .mcand  (op_a),
    .mplier (op_b),
    .acc    (mul_acc),
    .last   (mul_last)
  );
`else
  logic unused_mul_ctrl;
  assign unused_mul_ctrl = &{1'b0, mul_load, mul_step};
  assign mul_acc  = '0;
  assign mul_last = 1'b0;
`endif

  // Single-cycle op decode on the latched operands
  always_comb begin
    add9       = {1'b0, a_q} + {1'b0, b_q};
    sub9       = {1'b0, a_q} - {1'b0, b_q};
    alu_res    = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    alu_legal  = 1'b1;
    alu_writes = 1'b1;
    case (opc_q)
      OP_ADD: begin
        alu_res = add9[MSB:0];
        alu_c   = add9[DATA_W];
        alu_v   = (a_q[MSB] == b_q[MSB]) && (add9[MSB] != a_q[MSB]);
      end
      OP_SUB, OP_CMP: begin
        alu_res    = sub9[MSB:0];
        alu_c      = sub9[DATA_W];
        alu_v      = (a_q[MSB] != b_q[MSB]) && (sub9[MSB] != a_q[MSB]);
        alu_writes = (opc_q == OP_SUB);
      end
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_NOT: alu_res = ~a_q;
      OP_SHL: begin
        alu_res = {a_q[MSB-1:0], 1'b0};
        alu_c   = a_q[MSB];
      end
      OP_SHR: begin
        alu_res = {1'b0, a_q[MSB:1]};
        alu_c   = a_q[0];
      end
      default: begin
        alu_legal  = 1'b0;
        alu_writes = 1'b0;
      end
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = alu_c;
    alu_flags[FLAG_N] = alu_res[MSB];
    alu_flags[FLAG_V] = alu_v;
  end

  // Next-state and registered-output values
  always_comb begin
    state_d    = state;
    latch      = 1'b0;
    mul_load   = 1'b0;
    mul_step   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    we_d       = 1'b0;
    result_d   = result;
    mul_high_d = mul_high;
    wr_num_d   = wr_num;
    flags_d    = flags;
    case (state)
      ST_IDLE: begin
        if (start) begin
          latch = 1'b1;
          if (MUL_EN && (opcode == OP_MUL)) begin
            mul_load = 1'b1;
            state_d  = ST_MUL;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        state_d    = ST_IDLE;
        done_d     = 1'b1;
        result_d   = alu_res;
        mul_high_d = '0;
        wr_num_d   = dst_q;
        if (alu_legal) begin
          flags_d = alu_flags;
          we_d    = alu_writes;
        end else begin
          err_d = 1'b1;
        end
      end
      ST_MUL: begin
        if (mul_last) begin
          state_d             = ST_IDLE;
          done_d              = 1'b1;
          we_d                = 1'b1;
          result_d            = mul_acc[MSB:0];
          mul_high_d          = mul_acc[2*DATA_W-1:DATA_W];
          wr_num_d            = dst_q;
          flags_d             = '0;
          flags_d[FLAG_Z]     = (mul_acc == '0);
          flags_d[FLAG_C]     = (mul_acc[2*DATA_W-1:DATA_W] != '0);
        end else begin
          mul_step = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Operand latch and write-back bundle registers
  always_ff @(posedge clk) begin
    if (rst) begin
      opc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      dst_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      write_en <= 1'b0;
      result   <= '0;
      mul_high <= '0;
      wr_num   <= '0;
      flags    <= '0;
    end else begin
      if (latch) begin
        opc_q <= opcode;
        a_q   <= op_a;
        b_q   <= op_b;
        dst_q <= dst_num;
      end
      busy     <= busy_d;
      done     <= done_d;
      err      <= err_d;
      write_en <= we_d;
      result   <= result_d;
      mul_high <= mul_high_d;
      wr_num   <= wr_num_d;
      flags    <= flags_d;
    end
  end

endmodule

// File: doc/alu_exec.md
# alu_exec

Sequential execute stage of the 8-bit datapath, directly downstream of the general-purpose register file. It takes the two operands read from the register file, an opcode and a destination register number. It then produces a write-back bundle that drives the register file's write port: low result, multiply high byte, destination number and write enable. Single-cycle ALU ops and an 8-iteration shift-add multiply share one handshake.

## Interface
- DATA_W, 8, operand/result width (only 8 is supported)
- REG_AW, 3, register-number width
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- opcode  in  4  operation select
- op_a  in  DATA_W  first operand (register file A output)
- op_b  in  DATA_W  second operand (register file B output)
- dst_num  in  REG_AW  destination register, latched with start
- busy  out  1  high in EXEC or MUL state
- done  out  1  one-cycle completion pulse
- err  out  1  high with done for an illegal opcode
- result  out  DATA_W  low result, to register file write data
- mul_high  out  DATA_W  product high byte, to register file high-byte input
- wr_num  out  REG_AW  latched dst_num
- write_en  out  1  one-cycle write-back strobe
- flags  out  4  {V,N,C,Z}

## Operation
- Opcodes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A.
  - 6 SHL A by 1, 7 SHR A by 1 (logical), 8 MUL (unsigned 8x8→16), 9 CMP (A-B, flags only).
  - A–F are illegal.
- States: IDLE, EXEC, MUL.
  - IDLE: start=1 latches opcode, op_a, op_b and dst_num. Next state is MUL for opcode 8, EXEC otherwise.
  - EXEC: compute and register the outputs, then go to IDLE.
  - MUL: one shift-add iteration per cycle driven by a 3-bit counter. After the 8th iteration, register the outputs and go to IDLE.
- Write-back: write_en=1 and done=1 for exactly one cycle, in the cycle after the state returns to IDLE.
- mul_high is 0 for every non-MUL op, because the register file writes its high byte on every write.
- CMP and illegal opcodes: done=1 and write_en=0. err=1 only for illegal opcodes.
- Flags update only on done of a legal op. Illegal opcodes leave flags unchanged.
  - Z: 8-bit result is zero.
  - N: result bit 7.
  - C: ADD carry-out; SUB/CMP borrow (A<B); SHL old bit 7; SHR old bit 0; 0 for logic ops.
  - V: signed overflow for ADD/SUB/CMP; 0 otherwise.
  - MUL flags: Z is set when the 16-bit product is zero, C = (high byte != 0), N=0, V=0.
- start while busy=1 is ignored, with no queueing.

## Timing
- start sampled at edge N:
  - Non-MUL ops: outputs registered at edge N+1; write_en/done high between edges N+1 and N+2.
  - MUL: outputs registered at edge N+9.
- busy rises at edge N and falls at the same edge that write_en rises.
- Back-to-back: start is accepted during the write_en cycle.
- The register file must not be read-enabled during the write_en cycle, because its read has priority over write. The controller enforces this.
- Reset values: busy, done, err, write_en = 0; result, mul_high, wr_num, flags = 0; state IDLE; counter 0.
- Reset mid-operation: the in-flight op is discarded with no write_en or done, and state returns to IDLE on the reset edge.
- rst and start asserted in the same cycle: rst wins.

## Configuration
- ALU_MUL_EN defined: MUL is implemented as above.
- ALU_MUL_EN undefined: the multiplier is not built. Opcode 8 is treated as illegal (done=1, err=1, write_en=0, non-MUL latency) and the MUL state is unreachable.

## Structure
- Shared package alu_pkg holds:
  - opcode constants;
  - state enum;
  - flag bit indices (Z=0, C=1, N=2, V=3).
- One sub-module, alu_mul_seq, holds the shift-add multiplier. It has load/step inputs, the counter, a 16-bit accumulator and a last-iteration output.
- Combinational op decode stays in alu_exec.

## Test plan
- ADD 0x7F+0x01, dst 3 → result 0x80, mul_high 0x00, wr_num 3, flags V=1 N=1 C=0 Z=0, write_en exactly 2 edges after start.
- MUL 0xFF×0xFF → result 0x01, mul_high 0xFE, C=1, write_en at edge N+9. Also MUL 0x00×0x5A → Z=1.
- CMP 0x05,0x05 → done=1, write_en=0, Z=1, C=0. Opcode 0xC → done=1, err=1, flags unchanged.
- start pulsed during MUL iteration 3 → ignored, single write_en with the original product.
- rst asserted at MUL iteration 4 → no write_en/done, all outputs 0. A following ADD 0x01+0x01 → result 0x02.
- Back-to-back: SUB 0x00-0x01 followed by a start in its write_en cycle → first result 0xFF with C=1 N=1, second op completes 2 edges later.
